// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, issue-stage FSM states and small helpers
// used by the issue stage, its interface and the wrapping alu_unit top.
package alu_pkg;

    typedef logic [3:0] alu_ctrl_t;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_INC = 4'b0011,
        OP_DEC = 4'b0100,
        OP_NOT = 4'b0101,
        OP_SUB = 4'b0110,
        OP_XOR = 4'b0111,
        OP_SHL = 4'b1000,
        OP_SHR = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } issue_state_e;

    // Only the shifters produce a carry-out; every other op leaves the stored carry alone.
    function automatic logic is_shift(input alu_ctrl_t op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of the issue stage's upstream, ALU-facing and downstream signals.
// The stage uses the slave view; the driver of the stage (bench or alu_unit) uses master.
interface alu_issue_stage_if
    import alu_pkg::*;
#(
    parameter int bits  = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [bits-1:0]  in_a;
    logic [bits-1:0]  in_b;
    alu_ctrl_t        in_op;
    logic             in_flag;
    logic             in_chain;

    logic [bits-1:0]  alu_a;
    logic [bits-1:0]  alu_b;
    alu_ctrl_t        alu_ctrl;
    logic             alu_flag_in;
    logic [bits-1:0]  alu_result;
    logic             alu_zero;
    logic             alu_cflag;

    logic             out_valid;
    logic             out_ready;
    logic [bits-1:0]  out_result;
    logic             out_zero;
    logic             out_carry;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_flag, in_chain,
        input  alu_result, alu_zero, alu_cflag, out_ready,
        output in_ready, alu_a, alu_b, alu_ctrl, alu_flag_in,
        output out_valid, out_result, out_zero, out_carry, op_count
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_flag, in_chain,
        output alu_result, alu_zero, alu_cflag, out_ready,
        input  in_ready, alu_a, alu_b, alu_ctrl, alu_flag_in,
        input  out_valid, out_result, out_zero, out_carry, op_count
    );

endinterface

// File: rtl/alu_issue_stage.sv
// Registered issue/retire stage around the combinational ALU: accept an op, hold the
// ALU inputs for one EXEC cycle, capture result/flags, and hand off under backpressure.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int bits  = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_stage_if.slave   io
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_EXEC = ST_EXEC;
    localparam logic [1:0] S_HOLD = ST_HOLD;

    logic [1:0]       state_q,  state_d;
    logic [bits-1:0]  a_q,      a_d;
    logic [bits-1:0]  b_q,      b_d;
    alu_ctrl_t        ctrl_q,   ctrl_d;
    logic             flag_q,   flag_d;
    logic [bits-1:0]  result_q, result_d;
    logic             zero_q,   zero_d;
    logic             carry_q,  carry_d;
    logic             valid_q,  valid_d;
    logic [CNT_W-1:0] count_q,  count_d;

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a signal unassigned (no latches).
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        flag_d   = flag_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        valid_d  = valid_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.in_a;
                    b_d     = io.in_b;
                    ctrl_d  = io.in_op;
                    // Chaining picks up the carry retired by the previous op.
                    flag_d  = io.in_chain ? carry_q : io.in_flag;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = io.alu_result;
                zero_d   = io.alu_zero;
                if (is_shift(ctrl_q)) begin
                    carry_d = io.alu_cflag;
                end
                valid_d  = 1'b1;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (io.out_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            flag_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            flag_q   <= flag_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign io.in_ready    = (state_q == S_IDLE);
    assign io.alu_a       = a_q;
    assign io.alu_b       = b_q;
    assign io.alu_ctrl    = ctrl_q;
    assign io.alu_flag_in = flag_q;
    assign io.out_valid   = valid_q;
    assign io.out_result  = result_q;
    assign io.out_zero    = zero_q;
    assign io.out_carry   = carry_q;
    assign io.op_count    = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a small ALU model closes the loop, a vector table
// drives back-to-back ops, and hand sequences cover backpressure and reset corners.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.bits(4), .CNT_W(8)) bus  ();
    alu_issue_stage_if #(.bits(4), .CNT_W(2)) bus2 ();

    alu_issue_stage #(.bits(4), .CNT_W(8)) u_dut  (.clk(clk), .rst(rst), .io(bus.slave));
    alu_issue_stage #(.bits(4), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .io(bus2.slave));

    // Reference combinational ALU: {cflag, zero, result}. ADD folds in flag-in.
    function automatic logic [5:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] ctrl, input logic fin);
        logic [3:0] r;
        logic       c;
        c = 1'b0;
        case (ctrl)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b + {3'b000, fin};
            OP_INC:  r = a + 4'd1;
            OP_DEC:  r = a - 4'd1;
            OP_NOT:  r = ~a;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  begin r = {a[2:0], 1'b0}; c = a[3]; end
            OP_SHR:  begin r = {1'b0, a[3:1]}; c = a[0]; end
            default: r = 4'd0;
        endcase
        return {c, (r == 4'd0), r};
    endfunction

    always_comb {bus.alu_cflag, bus.alu_zero, bus.alu_result} =
        alu_model(bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.alu_flag_in);
    always_comb {bus2.alu_cflag, bus2.alu_zero, bus2.alu_result} =
        alu_model(bus2.alu_a, bus2.alu_b, bus2.alu_ctrl, bus2.alu_flag_in);

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_a      = bus.in_a;
    assign bus2.in_b      = bus.in_b;
    assign bus2.in_op     = bus.in_op;
    assign bus2.in_flag   = bus.in_flag;
    assign bus2.in_chain  = bus.in_chain;
    assign bus2.out_ready = bus.out_ready;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic       flag;
        logic       chain;
        logic [3:0] res;
        logic       zero;
        logic       carry;
        logic       fin;
    } vec_t;

    vec_t vecs[7];

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                         input logic flag, input logic chain);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_flag  = flag;
        bus.in_chain = chain;
        tick();
        // Scramble inputs after the accept edge: only the accept-edge values may matter.
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        bus.in_op    = OP_NOT;
        bus.in_flag  = ~flag;
        bus.in_chain = ~chain;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        issue(v.a, v.b, v.op, v.flag, v.chain);
        check($sformatf("v%0d_exec_in_ready", i), 32'(bus.in_ready), 32'd0);
        check($sformatf("v%0d_exec_alu_a", i), 32'(bus.alu_a), 32'(v.a));
        check($sformatf("v%0d_exec_alu_b", i), 32'(bus.alu_b), 32'(v.b));
        check($sformatf("v%0d_exec_alu_ctrl", i), 32'(bus.alu_ctrl), 32'(v.op));
        check($sformatf("v%0d_exec_flag_in", i), 32'(bus.alu_flag_in), 32'(v.fin));
        check($sformatf("v%0d_exec_out_valid", i), 32'(bus.out_valid), 32'd0);
        tick();
        check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
        check($sformatf("v%0d_out_result", i), 32'(bus.out_result), 32'(v.res));
        check($sformatf("v%0d_out_zero", i), 32'(bus.out_zero), 32'(v.zero));
        check($sformatf("v%0d_out_carry", i), 32'(bus.out_carry), 32'(v.carry));
        tick();
        exp_cnt++;
        check($sformatf("v%0d_handoff_valid", i), 32'(bus.out_valid), 32'd0);
        check($sformatf("v%0d_handoff_in_ready", i), 32'(bus.in_ready), 32'd1);
        check($sformatf("v%0d_op_count", i), 32'(bus.op_count), 32'(exp_cnt % 256));
        check($sformatf("v%0d_op_count_w2", i), 32'(bus2.op_count), 32'(exp_cnt % 4));
    endtask

    initial begin
        //         a        b      op      flag  chain res      zero  carry fin
        vecs[0] = '{4'd3,   4'd5,  OP_ADD, 1'b0, 1'b0, 4'd8,    1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'd5,   4'd5,  OP_SUB, 1'b0, 1'b0, 4'd0,    1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'b1001,4'd1,  OP_SHL, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{4'd2,   4'd3,  OP_ADD, 1'b0, 1'b1, 4'd6,    1'b0, 1'b1, 1'b1};
        vecs[4] = '{4'b0110,4'd0,  OP_SHR, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{4'hF,   4'd1,  OP_ADD, 1'b1, 1'b1, 4'd0,    1'b1, 1'b0, 1'b0};
        vecs[6] = '{4'hA,   4'h6,  OP_XOR, 1'b1, 1'b0, 4'hC,    1'b0, 1'b0, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.in_flag   = 1'b0;
        bus.in_chain  = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready",  32'(bus.in_ready),   32'd1);
        check("rst_out_valid", 32'(bus.out_valid),  32'd0);
        check("rst_alu_a",     32'(bus.alu_a),      32'd0);
        check("rst_alu_ctrl",  32'(bus.alu_ctrl),   32'd0);
        check("rst_out_res",   32'(bus.out_result), 32'd0);
        check("rst_out_carry", 32'(bus.out_carry),  32'd0);
        check("rst_op_count",  32'(bus.op_count),   32'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: 7+1=8 held for 10 cycles while a stray in_valid is ignored.
        bus.out_ready = 1'b0;
        issue(4'd7, 4'd1, OP_ADD, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = (c == 3);
            bus.in_a     = 4'd9;
            tick();
            check($sformatf("bp%0d_out_valid", c), 32'(bus.out_valid),  32'd1);
            check($sformatf("bp%0d_out_result", c), 32'(bus.out_result), 32'd8);
            check($sformatf("bp%0d_in_ready", c), 32'(bus.in_ready),   32'd0);
            check($sformatf("bp%0d_alu_a", c), 32'(bus.alu_a),      32'd7);
            check($sformatf("bp%0d_op_count", c), 32'(bus.op_count),   32'(exp_cnt));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        exp_cnt++;
        check("bp_release_valid",    32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready),  32'd1);
        check("bp_release_count",    32'(bus.op_count),  32'(exp_cnt));
        check("bp_release_count_w2", 32'(bus2.op_count), 32'(exp_cnt % 4));
        tick();
        check("bp_single_handoff",   32'(bus.op_count),  32'(exp_cnt));

        // Reset during EXEC aborts the op with no delivery and no count.
        issue(4'b1001, 4'd0, OP_SHL, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        check("rexec_out_valid", 32'(bus.out_valid),   32'd0);
        check("rexec_in_ready",  32'(bus.in_ready),    32'd1);
        check("rexec_alu_a",     32'(bus.alu_a),       32'd0);
        check("rexec_flag_in",   32'(bus.alu_flag_in), 32'd0);
        check("rexec_out_carry", 32'(bus.out_carry),   32'd0);
        check("rexec_op_count",  32'(bus.op_count),    32'd0);
        tick();
        check("rexec_no_deliver", 32'(bus.out_valid),  32'd0);

        // Reset coinciding with in_valid: no accept.
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a     = 4'd5;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        check("rvalid_in_ready", 32'(bus.in_ready), 32'd1);
        check("rvalid_alu_a",    32'(bus.alu_a),    32'd0);
        tick();
        check("rvalid_no_exec",  32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
